// File: rtl/aux_perf_monitor_if.sv
// Bus bundle for aux_perf_monitor: count controls, snapshot handshake and readout.
// master drives the controls; slave is the monitor itself.
interface aux_perf_monitor_if #(
    parameter int ChanCnt = 4,
    parameter int CntBit  = 32,
    parameter int SelBit  = 2
);
    logic               en;
    logic [ChanCnt-1:0] evt;
    logic               clr;
    logic               snap_req;
    logic               snap_rel;
    logic [SelBit-1:0]  sel;
    logic [CntBit-1:0]  rd_data;
    logic               snap_valid;
    logic [ChanCnt-1:0] ovf;

    modport master (
        output en, evt, clr, snap_req, snap_rel, sel,
        input  rd_data, snap_valid, ovf
    );

    modport slave (
        input  en, evt, clr, snap_req, snap_rel, sel,
        output rd_data, snap_valid, ovf
    );
endinterface

// File: rtl/aux_perf_monitor.sv
// Per-channel event counters with sticky overflow, a LIVE/HOLD snapshot FSM and registered readout.
// Define PERF_MON_SATURATE_EN to make counters saturate at all-ones instead of wrapping.
module aux_perf_monitor #(
    parameter int ChanCnt = 4,
    parameter int CntBit  = 32,
    parameter int SelBit  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    aux_perf_monitor_if.slave  bus
);

    typedef enum logic {
        LIVE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                           state_q;
    state_t                           state_d;
    logic                             capture;
    logic [ChanCnt-1:0][CntBit-1:0]   cnt_q;
    logic [ChanCnt-1:0][CntBit-1:0]   shadow_q;
    logic [ChanCnt-1:0]               ovf_q;
    logic [CntBit-1:0]                rd_q;
    logic [CntBit-1:0]                rd_d;
    logic                             snap_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LIVE;
        end else begin
            state_q <= state_d;
        end
    end

    // A simultaneous request and release while LIVE still enters HOLD.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            LIVE: begin
                if (bus.snap_req) begin
                    state_d = HOLD;
                    capture = 1'b1;
                end
            end
            HOLD: begin
                if (bus.snap_rel) begin
                    state_d = LIVE;
                end
            end
            default: state_d = LIVE;
        endcase
    end

    // clr wins over a coincident increment; overflow is sticky until clr or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= '0;
        end else if (bus.clr) begin
            cnt_q <= '0;
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < ChanCnt; i++) begin
                if (bus.en && bus.evt[i]) begin
                    if (cnt_q[i] == '1) begin
                        ovf_q[i] <= 1'b1;
`ifdef PERF_MON_SATURATE_EN
                        cnt_q[i] <= cnt_q[i];
`else
                        cnt_q[i] <= '0;
`endif
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CntBit'(1);
                    end
                end
            end
        end
    end

    // Shadows take pre-edge counts, so a capture coincident with clr keeps the old values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else if (capture) begin
            shadow_q <= cnt_q;
        end
    end

    always_comb begin
        rd_d = '0;
        for (int i = 0; i < ChanCnt; i++) begin
            if (int'(bus.sel) == i) begin
                rd_d = (state_q == HOLD) ? shadow_q[i] : cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q         <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            rd_q         <= rd_d;
            snap_valid_q <= (state_d == HOLD);
        end
    end

    assign bus.rd_data    = rd_q;
    assign bus.snap_valid = snap_valid_q;
    assign bus.ovf        = ovf_q;

endmodule
